spi_vec_bank: RTL

- Parametrised successor to the fixed six-vector POV loader.
- An SPI slave writes an arbitrary number of fixed-point registers into a shadow bank, either by addressed single writes or by burst writes.
- Registers that have been written are copied to the active outputs only on a frame-boundary strobe, so the tracer never sees a torn vector set mid-frame.
- Sits between the external SPI pins and wall_tracer/overlays; the top drives load_if_ready at the visible frame end.

---
 rtl/spi_vec_bank_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_vec_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_vec_bank_pkg.sv
// Shared definitions for the SPI vector bank.
// - FIXED_WIDTH : fixed-point word width used by the tracer; default register width.
// - Command byte layout: bit 7 selects burst mode, low bits carry the start address.
// - Named indices of the default six POV registers.
// - state_e : transaction FSM states.
package spi_vec_bank_pkg;

    localparam int unsigned FIXED_WIDTH  = 16;
    localparam int unsigned CMD_BITS     = 8;
    localparam int unsigned CMD_MODE_BIT = 7;

    localparam int unsigned PLAYER_X = 0;
    localparam int unsigned PLAYER_Y = 1;
    localparam int unsigned FACING_X = 2;
    localparam int unsigned FACING_Y = 3;
    localparam int unsigned VPLANE_X = 4;
    localparam int unsigned VPLANE_Y = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and detects edges.
// Ports:
//   clk, reset      : system clock, asynchronous active-low reset
//   i_sclk/i_mosi/i_ss_n : raw SPI pins
//   o_sclk_rise     : one-cycle pulse on a synchronised sclk rising edge
//   o_ss_fall/o_ss_rise : one-cycle pulses on synchronised select edges
//   o_mosi_s        : synchronised MOSI, aligned with o_sclk_rise
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_ss_n,
    output logic o_sclk_rise,
    output logic o_ss_fall,
    output logic o_ss_rise,
    output logic o_mosi_s
);

    // Stages [1:0] are the synchroniser, stage [2] holds the previous sample.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_ss_sync;
    logic [1:0] r_mosi_sync;

    // The select chain resets low: if ss_n is still low when reset releases (reset
    // mid-transaction) no falling edge is seen, so the remainder of that transaction
    // is ignored. A select held high only produces a harmless rise in idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[1:0], i_ss_n};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    assign o_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign o_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign o_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign o_mosi_s    = r_mosi_sync[1];

endmodule

// File: rtl/spi_vec_bank.sv
// SPI-loaded bank of fixed-point registers with frame-synchronous activation.
// Writes land in per-transaction staging, are committed to a shadow bank when the
// select rises, and reach o_regs only on a load_if_ready strobe.
// Ports:
//   clk, reset       : system clock, asynchronous active-low reset
//   i_sclk, i_mosi, i_ss_n : SPI mode-0 slave pins (async to clk)
//   load_if_ready    : frame-boundary strobe
//   o_regs           : active register image, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   o_loaded         : one-cycle pulse when o_regs was updated
//   o_pending        : some shadow register is awaiting load
//   o_err            : sticky bad-address / burst-overrun flag
module spi_vec_bank
    import spi_vec_bank_pkg::*;
#(
    parameter int unsigned                   NUM_REGS     = 6,
    parameter int unsigned                   REG_WIDTH    = FIXED_WIDTH,
    parameter int unsigned                   ADDR_BITS    = 4,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_sclk,
    input  logic                          i_mosi,
    input  logic                          i_ss_n,
    input  logic                          load_if_ready,
    output logic [NUM_REGS*REG_WIDTH-1:0] o_regs,
    output logic                          o_loaded,
    output logic                          o_pending,
    output logic                          o_err
);

    localparam int unsigned CNT_W = $clog2(REG_WIDTH > CMD_BITS ? REG_WIDTH : CMD_BITS);

    logic w_sclk_rise, w_ss_fall, w_ss_rise, w_mosi_s;

    spi_sync_edge u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_sclk      (i_sclk),
        .i_mosi      (i_mosi),
        .i_ss_n      (i_ss_n),
        .o_sclk_rise (w_sclk_rise),
        .o_ss_fall   (w_ss_fall),
        .o_ss_rise   (w_ss_rise),
        .o_mosi_s    (w_mosi_s)
    );

    state_e                        r_state, w_state_d;
    logic [CNT_W-1:0]              r_bit_cnt;
    logic [CMD_BITS-2:0]           r_cmd;
    logic [REG_WIDTH-2:0]          r_word;
    logic [ADDR_BITS-1:0]          r_addr;
    logic                          r_burst;
    logic                          r_txn_err;
    logic [NUM_REGS*REG_WIDTH-1:0] r_stage;
    logic [NUM_REGS-1:0]           r_stage_vld;
    logic [NUM_REGS*REG_WIDTH-1:0] r_shadow;
    logic [NUM_REGS-1:0]           r_dirty;
    logic [NUM_REGS*REG_WIDTH-1:0] r_regs;
    logic                          r_loaded;
    logic                          r_err;

    logic [CMD_BITS-1:0]  w_cmd_byte;
    logic [ADDR_BITS-1:0] w_cmd_addr;
    logic [REG_WIDTH-1:0] w_word;
    logic                 w_shift_cmd, w_shift_data;
    logic                 w_cmd_done, w_bad_addr, w_word_done, w_overrun;
    logic                 w_commit, w_load;

    assign w_cmd_byte = {r_cmd, w_mosi_s};
    assign w_cmd_addr = w_cmd_byte[ADDR_BITS-1:0];
    assign w_word     = {r_word, w_mosi_s};
    assign w_commit   = w_ss_rise & (|r_stage_vld);
    assign w_load     = load_if_ready & (|r_dirty);

    always_comb begin
        w_state_d    = r_state;
        w_shift_cmd  = 1'b0;
        w_shift_data = 1'b0;
        w_cmd_done   = 1'b0;
        w_bad_addr   = 1'b0;
        w_word_done  = 1'b0;
        w_overrun    = 1'b0;
        if (w_ss_rise) begin
            w_state_d = StIdle;
        end else if (w_ss_fall) begin
            w_state_d = StCmd;
        end else if (w_sclk_rise) begin
            unique case (r_state)
                StCmd: begin
                    w_shift_cmd = 1'b1;
                    if (r_bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                        w_cmd_done = 1'b1;
                        w_bad_addr = 32'(w_cmd_addr) >= NUM_REGS;
                        w_state_d  = w_bad_addr ? StDone : StData;
                    end
                end
                StData: begin
                    w_shift_data = 1'b1;
                    if (r_bit_cnt == CNT_W'(REG_WIDTH - 1)) begin
                        w_word_done = 1'b1;
                        if (!r_burst || r_addr == ADDR_BITS'(NUM_REGS - 1)) begin
                            w_state_d = StDone;
                        end
                    end
                end
                StDone:  w_overrun = r_burst;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_cmd       <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_burst     <= 1'b0;
            r_txn_err   <= 1'b0;
            r_stage     <= RESET_VALUES;
            r_stage_vld <= '0;
            r_shadow    <= RESET_VALUES;
            r_dirty     <= '0;
            r_regs      <= RESET_VALUES;
            r_loaded    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_loaded <= w_load;

            if (w_ss_fall) begin
                r_bit_cnt   <= '0;
                r_stage_vld <= '0;
                r_txn_err   <= 1'b0;
            end

            if (w_shift_cmd || w_shift_data) begin
                r_bit_cnt <= (w_cmd_done || w_word_done) ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_shift_cmd) begin
                r_cmd <= w_cmd_byte[CMD_BITS-2:0];
            end
            if (w_shift_data) begin
                r_word <= w_word[REG_WIDTH-2:0];
            end

            if (w_cmd_done) begin
                r_burst <= w_cmd_byte[CMD_MODE_BIT];
                r_addr  <= w_cmd_addr;
            end
            if (w_bad_addr || w_overrun) begin
                r_err     <= 1'b1;
                r_txn_err <= 1'b1;
            end

            if (w_word_done) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (r_addr == ADDR_BITS'(i)) begin
                        r_stage[i*REG_WIDTH +: REG_WIDTH] <= w_word;
                        r_stage_vld[i]                    <= 1'b1;
                    end
                end
                r_addr <= r_addr + 1'b1;
            end

            // An error raised inside the committing transaction survives its own
            // commit; only errors from earlier transactions are cleared.
            if (w_ss_rise) begin
                r_stage_vld <= '0;
            end
            if (w_commit) begin
                r_err <= r_txn_err;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (r_stage_vld[i]) begin
                        r_shadow[i*REG_WIDTH +: REG_WIDTH] <= r_stage[i*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end

            // Load reads the pre-commit shadow; commit sets win over load clears.
            if (w_load) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (r_dirty[i]) begin
                        r_regs[i*REG_WIDTH +: REG_WIDTH] <= r_shadow[i*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
            r_dirty <= (r_dirty & ~(w_load ? r_dirty : '0)) | (w_commit ? r_stage_vld : '0);
        end
    end

    assign o_regs    = r_regs;
    assign o_loaded  = r_loaded;
    assign o_pending = |r_dirty;
    assign o_err     = r_err;

endmodule
